// File: rtl/multicycle_dispatcher.sv
// multicycle_dispatcher: routes fetched instructions to single-cycle or stepped multicycle decoders
module multicycle_dispatcher #(
  parameter int INSTR_W  = 9,
  parameter int OPCODE_W = 8,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  curr_instruction,
  input  logic [STEP_W-1:0]   step_count,
  input  logic                flush,
  output logic [OPCODE_W-1:0] output_to_opcode,
  output logic                opcode_valid,
  output logic [OPCODE_W-1:0] output_to_multicycle_opcode,
  output logic                mc_valid,
  output logic [STEP_W-1:0]   mc_step,
  output logic                mc_last,
  output logic                busy
);
  typedef enum logic {IDLE, MULTI} state_t;
  state_t state, state_nxt;
  logic [OPCODE_W-1:0] sc_op, mc_op, op;
  logic [STEP_W-1:0] step, rem, n_m1;
  logic sc_valid, accept, is_mc, last;
  assign op     = curr_instruction[OPCODE_W-1:0];
  assign is_mc  = curr_instruction[INSTR_W-1];
  assign n_m1   = (step_count == '0) ? '0 : step_count - 1'b1;
  assign last   = (state == MULTI) && (rem == '0);
  assign accept = instr_valid && instr_ready;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // next state: flush wins, a new accept overrides, otherwise keep stepping until the last step
  always_comb
    state_nxt = flush ? IDLE :
                accept ? (is_mc ? MULTI : IDLE) :
                (state == MULTI && !last) ? MULTI : IDLE;
  // opcode latches, single-cycle valid and step bookkeeping (rem counts steps left after the current one)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sc_valid <= 1'b0;
      sc_op    <= '0;
      mc_op    <= '0;
      step     <= '0;
      rem      <= '0;
    end else if (flush) begin
      sc_valid <= 1'b0;
      step     <= '0;
      rem      <= '0;
    end else if (accept) begin
      sc_valid <= !is_mc;
      sc_op    <= is_mc ? sc_op : op;
      mc_op    <= is_mc ? op : mc_op;
      step     <= '0;
      rem      <= is_mc ? n_m1 : '0;
    end else if (state == MULTI && !last) begin
      sc_valid <= 1'b0;
      step     <= step + 1'b1;
      rem      <= rem - 1'b1;
    end else begin
      sc_valid <= 1'b0;
      step     <= '0;
      rem      <= '0;
    end
  // outputs: opcodes and step index forced to zero whenever their qualifier is low
  always_comb begin
    instr_ready                 = !flush && (state == IDLE || last);
    busy                        = state == MULTI;
    mc_valid                    = busy;
    mc_last                     = last;
    mc_step                     = busy ? step : '0;
    output_to_multicycle_opcode = busy ? mc_op : '0;
    opcode_valid                = sc_valid;
    output_to_opcode            = sc_valid ? sc_op : '0;
  end
endmodule

// File: tb/tb_multicycle_dispatcher.sv
// tb_multicycle_dispatcher: table-driven scoreboard bench for multicycle_dispatcher
module tb_multicycle_dispatcher;
  logic clk = 1'b0, reset_n = 1'b0, instr_valid = 1'b0, flush = 1'b0;
  logic [8:0] curr_instruction = '0;
  logic [2:0] step_count = '0;
  logic instr_ready, opcode_valid, mc_valid, mc_last, busy;
  logic [7:0] output_to_opcode, output_to_multicycle_opcode;
  logic [2:0] mc_step;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        v;
    logic [8:0]  ins;
    logic [2:0]  sc;
    logic        f;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [22:0] sb[$];

  multicycle_dispatcher dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .curr_instruction(curr_instruction), .step_count(step_count), .flush(flush),
    .output_to_opcode(output_to_opcode), .opcode_valid(opcode_valid),
    .output_to_multicycle_opcode(output_to_multicycle_opcode), .mc_valid(mc_valid),
    .mc_step(mc_step), .mc_last(mc_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mk(logic opv, logic [7:0] op, logic mcv, logic [7:0] mop,
                                     logic [2:0] st, logic lst, logic bsy);
    return {opv, op, mcv, mop, st, lst, bsy};
  endfunction

  function automatic logic [22:0] outs();
    return {opcode_valid, output_to_opcode, mc_valid, output_to_multicycle_opcode, mc_step, mc_last, busy};
  endfunction

  task automatic chk(string name, logic [22:0] got, logic [22:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(logic v, logic [8:0] ins, logic [2:0] sc, logic f, logic rdy, logic [22:0] exp);
    vecs.push_back('{v: v, ins: ins, sc: sc, f: f, rdy: rdy, exp: exp});
  endtask

  task automatic apply(vec_t t, string name);
    @(negedge clk);
    instr_valid = t.v;
    curr_instruction = t.ins;
    step_count = t.sc;
    flush = t.f;
    #1 chk({name, " ready"}, 23'(instr_ready), 23'(t.rdy));
    sb.push_back(t.exp);
    @(posedge clk);
    #1 chk({name, " outs"}, outs(), sb.pop_front());
  endtask

  initial begin
    logic [22:0] z;
    z = '0;
    // single-cycle stream
    add(1, 9'h012, 0, 0, 1, mk(1, 8'h12, 0, 0, 0, 0, 0));
    add(1, 9'h0A5, 0, 0, 1, mk(1, 8'hA5, 0, 0, 0, 0, 0));
    add(1, 9'h0FF, 0, 0, 1, mk(1, 8'hFF, 0, 0, 0, 0, 0));
    add(0, 9'h000, 0, 0, 1, z);
    // multicycle N=3, fetch keeps offering a word that must not be taken
    add(1, 9'h1C3, 3, 0, 1, mk(0, 0, 1, 8'hC3, 0, 0, 1));
    add(1, 9'h0EE, 0, 0, 0, mk(0, 0, 1, 8'hC3, 1, 0, 1));
    add(0, 9'h000, 0, 0, 0, mk(0, 0, 1, 8'hC3, 2, 1, 1));
    add(0, 9'h000, 0, 0, 1, z);
    // back-to-back on mc_last
    add(1, 9'h181, 2, 0, 1, mk(0, 0, 1, 8'h81, 0, 0, 1));
    add(1, 9'h182, 1, 0, 0, mk(0, 0, 1, 8'h81, 1, 1, 1));
    add(1, 9'h182, 1, 0, 1, mk(0, 0, 1, 8'h82, 0, 1, 1));
    add(1, 9'h033, 0, 0, 1, mk(1, 8'h33, 0, 0, 0, 0, 0));
    add(0, 9'h000, 0, 0, 1, z);
    // step_count 0 behaves as 1
    add(1, 9'h155, 0, 0, 1, mk(0, 0, 1, 8'h55, 0, 1, 1));
    add(0, 9'h000, 0, 0, 1, z);
    // flush at step 1 of N=5, held instruction taken afterwards
    add(1, 9'h1AA, 5, 0, 1, mk(0, 0, 1, 8'hAA, 0, 0, 1));
    add(0, 9'h000, 0, 0, 0, mk(0, 0, 1, 8'hAA, 1, 0, 1));
    add(1, 9'h044, 0, 1, 0, z);
    add(1, 9'h044, 0, 0, 1, mk(1, 8'h44, 0, 0, 0, 0, 0));
    add(0, 9'h000, 0, 0, 1, z);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset outs", outs(), z);
    chk("reset ready", 23'(instr_ready), 23'(1));
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk("post-reset outs", outs(), z);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset between edges during MULTI
    apply('{v: 1, ins: 9'h1B7, sc: 7, f: 0, rdy: 1, exp: mk(0, 0, 1, 8'hB7, 0, 0, 1)}, "rst acc");
    apply('{v: 0, ins: 9'h000, sc: 0, f: 0, rdy: 0, exp: mk(0, 0, 1, 8'hB7, 1, 0, 1)}, "rst step1");
    #2 reset_n = 1'b0;
    #1 chk("async rst outs", outs(), z);
    chk("async rst ready", 23'(instr_ready), 23'(1));
    #1 reset_n = 1'b1;
    apply('{v: 1, ins: 9'h07E, sc: 0, f: 0, rdy: 1, exp: mk(1, 8'h7E, 0, 0, 0, 0, 0)}, "after rst");
    apply('{v: 0, ins: 9'h000, sc: 0, f: 0, rdy: 1, exp: z}, "after rst idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_dispatcher.md
# multicycle_dispatcher

Registered, parametrised dispatcher between instruction fetch and the two decoders of the multicycle i281 core. Each accepted instruction goes either to the single-cycle opcode decoder or to the multicycle opcode decoder, selected by the instruction's top bit. Multicycle instructions are held and stepped for a per-instruction number of cycles, with a step index, a last-step marker and backpressure to fetch. A synchronous flush aborts dispatch on branch or exception.

## Interface
Parameters:
- INSTR_W, 9, instruction width; bit INSTR_W-1 is the multicycle flag.
- OPCODE_W, 8, forwarded opcode width; opcode = curr_instruction[OPCODE_W-1:0]; legal only if OPCODE_W <= INSTR_W-1.
- STEP_W, 3, step counter width; maximum step count is 2^STEP_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  dispatcher can accept; an instruction is accepted on a rising edge where instr_valid && instr_ready.
- curr_instruction  in  INSTR_W  instruction word.
- step_count  in  STEP_W  number of multicycle steps; sampled at accept; 0 is treated as 1.
- flush  in  1  synchronous abort; highest priority.
- output_to_opcode  out  OPCODE_W  opcode to the single-cycle decoder; 0 when opcode_valid is low.
- opcode_valid  out  1  one-cycle qualifier for output_to_opcode.
- output_to_multicycle_opcode  out  OPCODE_W  opcode to the multicycle decoder; 0 when mc_valid is low.
- mc_valid  out  1  multicycle opcode valid for the current step.
- mc_step  out  STEP_W  current step index, starting at 0; 0 when mc_valid is low.
- mc_last  out  1  high on the final step only.
- busy  out  1  high while in the MULTI state.

## Operation
- States are IDLE and MULTI. Registers: state, opcode register, remaining-step count, step index, and the output valids.
- instr_ready = !flush && (state==IDLE || mc_last). This is combinational from registered state and flush.
- Single-cycle accept (flag=0):
  - On the next cycle, output_to_opcode = opcode and opcode_valid = 1 for exactly one cycle.
  - State stays or returns to IDLE.
  - Back-to-back single-cycle instructions are accepted every cycle.
- Multicycle accept (flag=1):
  - Latch the opcode and N = max(step_count,1); enter MULTI.
  - For N consecutive cycles, mc_valid = 1 and output_to_multicycle_opcode = the latched opcode.
  - mc_step counts 0..N-1; mc_last = 1 when mc_step == N-1.
- On the mc_last cycle, a new instruction may be accepted.
  - A multicycle instruction restarts MULTI with step 0 on the next cycle, with no bubble.
  - A single-cycle instruction gives opcode_valid on the next cycle, and state goes to IDLE.
  - If nothing is accepted, the next state is IDLE with all valids 0.
- opcode_valid and mc_valid are never high in the same cycle.
- Flush: on an edge where flush = 1, go to IDLE and clear all valids, mc_step and mc_last. No instruction is accepted in that cycle. Outputs are all zero on the following cycle.
- Reset, including mid-MULTI, asynchronously forces:
  - state=IDLE;
  - output_to_opcode=0, opcode_valid=0;
  - output_to_multicycle_opcode=0, mc_valid=0, mc_step=0, mc_last=0;
  - busy=0.
- instr_ready=1 after reset when flush=0.

## Timing
- Latency from accept edge to valid output is 1 cycle, for both paths.
- A multicycle instruction occupies exactly N output cycles.
- instr_ready is low for the first N-1 of those cycles.
- Throughput: 1 instruction/cycle single-cycle; 1 per N cycles multicycle.
- busy equals (state==MULTI) and is registered; it is high on the same cycles as mc_valid.
- curr_instruction and step_count are don't-care except at accept.

## Test plan
- Reset then single-cycle stream: instructions 0x012, 0x0A5, 0x0FF on three consecutive cycles with instr_valid=1 → opcode_valid high for 3 cycles starting 1 cycle later; output_to_opcode = 0x12, 0xA5, 0xFF; mc_valid=0 throughout.
- Multicycle, step_count=3: instr 0x1C3 → mc_valid for 3 cycles, output_to_multicycle_opcode=0xC3, mc_step=0,1,2, mc_last only at step 2; instr_ready low for 2 cycles.
- Back-to-back on mc_last: 0x181 with step_count=2, then 0x182 with step_count=1 presented continuously → steps 0,1 of 0x81, then step 0 of 0x82 with mc_last=1, no gap; then 0x033 → opcode_valid with 0x33 on the next cycle.
- step_count=0: instr 0x155 → exactly one mc_valid cycle, mc_step=0, mc_last=1.
- Flush at mc_step=1 of a step_count=5 instruction → next cycle all outputs 0, busy=0; an instr_valid held during the flush cycle is not accepted and is accepted on the following cycle.
- Assert reset_n low mid-MULTI, asynchronously between edges → all outputs 0 immediately; after release, instr_ready=1 and a new single-cycle instruction dispatches normally.
